// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Wishbone memory arbiter for video DMA, sound DMA and CPU.
//             Fixed priority vid > snd > cpu, decided only in IDLE. DMA owners
//             get fixed-length incrementing bursts; the CPU gets one classic
//             transfer per grant. Every ownership ends with one GAP cycle.
//  Options  : `define MEM_ARB_TIMEOUT_EN to add an 8-bit watchdog that drops
//             a stalled memory cycle. A stalled CPU transfer then gets
//             cpu_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic        clkcpu,
    input  logic        rst_n_i,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [21:0] cpu_adr_i,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    input  logic        vid_req_i,
    input  logic [21:0] vid_adr_i,
    output logic        vid_ack_o,
    input  logic        snd_req_i,
    input  logic [21:0] snd_adr_i,
    output logic        snd_ack_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [2:0]  mem_cti_o,
    output logic [21:0] mem_adr_o,
    input  logic        mem_ack_i
);

    localparam int                    c_beat_w      = $clog2(BURST_LEN);
    localparam logic [c_beat_w-1:0]   c_last_beat   = c_beat_w'(BURST_LEN - 1);
    localparam logic [2:0]            c_cti_classic = 3'b000;
    localparam logic [2:0]            c_cti_incr    = 3'b010;
    localparam logic [2:0]            c_cti_eob     = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        VID  = 3'd1,
        SND  = 3'd2,
        CPU  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_mem_cyc;
    logic                  w_mem_cyc;
    logic                  r_mem_we;
    logic                  w_mem_we;
    logic [3:0]            r_mem_sel;
    logic [3:0]            w_mem_sel;
    logic [2:0]            r_mem_cti;
    logic [2:0]            w_mem_cti;
    logic [21:0]           r_mem_adr;
    logic [21:0]           w_mem_adr;
    logic [c_beat_w-1:0]   r_beat;
    logic [c_beat_w-1:0]   w_beat;
    logic [c_beat_w-1:0]   w_beat_inc;
    logic                  w_cpu_req;
    logic                  w_grant;
    logic                  w_timeout;

    assign w_cpu_req  = cpu_cyc_i & cpu_stb_i;
    assign w_grant    = (r_state == IDLE) & (vid_req_i | snd_req_i | w_cpu_req);
    assign w_beat_inc = r_beat + c_beat_w'(1);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] r_tmo;
    logic       r_cpu_err;

    // Stall watchdog: restarts on grant or ack, runs while a cycle is open.
    // Firing when the count is about to reach 255 means the cycle is held
    // for exactly 255 clocks without an ack.
    assign w_timeout = r_mem_cyc & ~mem_ack_i & (r_tmo == 8'hFE);

    // Watchdog counter and the one-cycle CPU error pulse it produces.
    always_ff @(posedge clkcpu) begin
        if (!rst_n_i) begin
            r_tmo     <= 8'd0;
            r_cpu_err <= 1'b0;
        end else begin
            r_cpu_err <= w_timeout & (r_state == CPU);
            if (w_grant || mem_ack_i) begin
                r_tmo <= 8'd0;
            end else if (r_mem_cyc) begin
                r_tmo <= r_tmo + 8'd1;
            end
        end
    end

    assign cpu_err_o = r_cpu_err;
`else
    assign w_timeout = 1'b0;
    assign cpu_err_o = 1'b0;
`endif

    // State and registered memory-bus outputs.
    always_ff @(posedge clkcpu) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_mem_cyc <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_sel <= 4'd0;
            r_mem_cti <= 3'd0;
            r_mem_adr <= 22'd0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_cyc <= w_mem_cyc;
            r_mem_we  <= w_mem_we;
            r_mem_sel <= w_mem_sel;
            r_mem_cti <= w_mem_cti;
            r_mem_adr <= w_mem_adr;
            r_beat    <= w_beat;
        end
    end

    // Arbitration, burst sequencing and end-of-ownership handling.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_cyc   = r_mem_cyc;
        w_mem_we    = r_mem_we;
        w_mem_sel   = r_mem_sel;
        w_mem_cti   = r_mem_cti;
        w_mem_adr   = r_mem_adr;
        w_beat      = r_beat;

        case (r_state)
            IDLE: begin
                if (vid_req_i) begin
                    w_state_nxt = VID;
                    w_mem_cyc   = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_sel   = 4'hF;
                    w_mem_cti   = c_cti_incr;
                    w_mem_adr   = vid_adr_i;
                    w_beat      = '0;
                end else if (snd_req_i) begin
                    w_state_nxt = SND;
                    w_mem_cyc   = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_sel   = 4'hF;
                    w_mem_cti   = c_cti_incr;
                    w_mem_adr   = snd_adr_i;
                    w_beat      = '0;
                end else if (w_cpu_req) begin
                    w_state_nxt = CPU;
                    w_mem_cyc   = 1'b1;
                    w_mem_we    = cpu_we_i;
                    w_mem_sel   = cpu_sel_i;
                    w_mem_cti   = c_cti_classic;
                    w_mem_adr   = cpu_adr_i;
                    w_beat      = '0;
                end
            end
            VID, SND: begin
                if (w_timeout || (mem_ack_i && (r_beat == c_last_beat))) begin
                    w_state_nxt = GAP;
                    w_mem_cyc   = 1'b0;
                    w_mem_we    = 1'b0;
                    w_mem_sel   = 4'd0;
                    w_mem_cti   = c_cti_classic;
                end else if (mem_ack_i) begin
                    w_beat    = w_beat_inc;
                    w_mem_adr = r_mem_adr + 22'd1;
                    w_mem_cti = (w_beat_inc == c_last_beat) ? c_cti_eob : c_cti_incr;
                end
            end
            CPU: begin
                if (w_timeout || mem_ack_i) begin
                    w_state_nxt = GAP;
                    w_mem_cyc   = 1'b0;
                    w_mem_we    = 1'b0;
                    w_mem_sel   = 4'd0;
                    w_mem_cti   = c_cti_classic;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_mem_cyc   = 1'b0;
            end
        endcase
    end

    // Acks follow mem_ack_i only toward the current owner.
    assign vid_ack_o = mem_ack_i & (r_state == VID);
    assign snd_ack_o = mem_ack_i & (r_state == SND);
    assign cpu_ack_o = mem_ack_i & (r_state == CPU);

    assign mem_cyc_o = r_mem_cyc;
    assign mem_stb_o = r_mem_cyc;
    assign mem_we_o  = r_mem_we;
    assign mem_sel_o = r_mem_sel;
    assign mem_cti_o = r_mem_cti;
    assign mem_adr_o = r_mem_adr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Expected transfers are
//             built as a queue of beats from the arbitration rules; the bench
//             plays the memory slave and compares every acked beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int BL = 4;

    logic        clkcpu = 1'b0;
    logic        rst_n_i;
    logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [21:0] cpu_adr_i;
    logic        cpu_ack_o, cpu_err_o;
    logic        vid_req_i;
    logic [21:0] vid_adr_i;
    logic        vid_ack_o;
    logic        snd_req_i;
    logic [21:0] snd_adr_i;
    logic        snd_ack_o;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [2:0]  mem_cti_o;
    logic [21:0] mem_adr_o;
    logic        mem_ack_i;

    mem_arbiter #(.BURST_LEN(BL)) dut (
        .clkcpu    (clkcpu),
        .rst_n_i   (rst_n_i),
        .cpu_cyc_i (cpu_cyc_i),
        .cpu_stb_i (cpu_stb_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_adr_i (cpu_adr_i),
        .cpu_ack_o (cpu_ack_o),
        .cpu_err_o (cpu_err_o),
        .vid_req_i (vid_req_i),
        .vid_adr_i (vid_adr_i),
        .vid_ack_o (vid_ack_o),
        .snd_req_i (snd_req_i),
        .snd_adr_i (snd_adr_i),
        .snd_ack_o (snd_ack_o),
        .mem_cyc_o (mem_cyc_o),
        .mem_stb_o (mem_stb_o),
        .mem_we_o  (mem_we_o),
        .mem_sel_o (mem_sel_o),
        .mem_cti_o (mem_cti_o),
        .mem_adr_o (mem_adr_o),
        .mem_ack_i (mem_ack_i)
    );

    always #5 clkcpu = ~clkcpu;

    typedef struct {
        logic [21:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  acks;   // {vid, snd, cpu}
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wait_mode = 0;     // >=0 fixed wait states, <0 random 0..3
    bit          spurious = 1'b0;   // drive mem_ack_i while no cycle is open
    int          late_snd_at = -1;
    logic [21:0] late_snd_adr = 22'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a DMA burst is BL consecutive words, last one marked end-of-burst.
    function automatic void push_dma(input logic [21:0] adr, input int who);
        beat_t b;
        for (int i = 0; i < BL; i++) begin
            b.adr  = adr + 22'(i);
            b.cti  = (i == BL - 1) ? 3'b111 : 3'b010;
            b.we   = 1'b0;
            b.sel  = 4'hF;
            b.acks = (who == 0) ? 3'b100 : 3'b010;
            b.last = (i == BL - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic void push_cpu(input logic [21:0] adr, input logic we, input logic [3:0] sel);
        beat_t b;
        b.adr  = adr;
        b.cti  = 3'b000;
        b.we   = we;
        b.sel  = sel;
        b.acks = 3'b001;
        b.last = 1'b1;
        exp_q.push_back(b);
    endfunction

    function automatic int pick_wait();
        return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    endfunction

    // Plays the memory slave until all expected beats are consumed.
    task automatic run_traffic(input int budget);
        int    idle_run = 0;
        bit    started = 1'b0;
        bit    expect_gap = 1'b0;
        int    popped = 0;
        int    waitc;
        logic  ack;
        beat_t e;
        waitc = pick_wait();
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            if (mem_cyc_o) begin
                ack = (waitc == 0);
                if (waitc > 0) waitc--;
            end else begin
                ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            mem_ack_i = ack;
            #1;
            if (mem_cyc_o) begin
                if (started && (idle_run != 0 || expect_gap))
                    chk("idle_cycles_between", idle_run, expect_gap ? 2 : 0);
                started    = 1'b1;
                idle_run   = 0;
                expect_gap = 1'b0;
            end else begin
                idle_run++;
            end
            if (mem_cyc_o && ack) begin
                e = exp_q.pop_front();
                popped++;
                chk("beat_adr", mem_adr_o, e.adr);
                chk("beat_cti", mem_cti_o, e.cti);
                chk("beat_we", mem_we_o, e.we);
                chk("beat_sel", mem_sel_o, e.sel);
                chk("beat_stb", mem_stb_o, 1'b1);
                chk("beat_owner_ack", {vid_ack_o, snd_ack_o, cpu_ack_o}, e.acks);
                if (e.acks == 3'b100) vid_req_i = 1'b0;
                if (e.acks == 3'b010) snd_req_i = 1'b0;
                if (e.acks == 3'b001) begin cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; end
                expect_gap = e.last;
                if (popped == late_snd_at) begin
                    snd_req_i = 1'b1;
                    snd_adr_i = late_snd_adr;
                    push_dma(late_snd_adr, 1);
                end
                waitc = pick_wait();
            end else begin
                chk("no_ack_pulse", {vid_ack_o, snd_ack_o, cpu_ack_o}, 3'b000);
            end
            @(posedge clkcpu); #1;
        end
        chk("traffic_done_in_budget", exp_q.size(), 0);
        exp_q.delete();
        mem_ack_i = 1'b0;
    endtask

    // With no requests pending the bus must stay quiet even if acks arrive.
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack_i = 1'b1;
            #1;
            chk("idle_cyc", mem_cyc_o, 1'b0);
            chk("idle_acks", {vid_ack_o, snd_ack_o, cpu_ack_o, cpu_err_o}, 4'b0000);
            @(posedge clkcpu); #1;
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int errs;
        bit v, s, c;
        logic [21:0] a;

        rst_n_i = 1'b0;
        cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
        cpu_sel_i = 4'd0; cpu_adr_i = 22'd0;
        vid_req_i = 1'b0; vid_adr_i = 22'd0;
        snd_req_i = 1'b0; snd_adr_i = 22'd0;
        mem_ack_i = 1'b1;
        repeat (3) @(posedge clkcpu);
        #1;
        // Reset state
        chk("rst_cyc", mem_cyc_o, 1'b0);
        chk("rst_stb", mem_stb_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_sel", mem_sel_o, 4'd0);
        chk("rst_cti", mem_cti_o, 3'd0);
        chk("rst_adr", mem_adr_o, 22'd0);
        chk("rst_acks", {vid_ack_o, snd_ack_o, cpu_ack_o, cpu_err_o}, 4'b0000);
        mem_ack_i = 1'b0;
        rst_n_i = 1'b1;

        // Single video burst, memory acks every cycle
        vid_req_i = 1'b1; vid_adr_i = 22'h000100;
        push_dma(22'h000100, 0);
        wait_mode = 0; spurious = 1'b1;
        run_traffic(50);
        idle_check(3);

        // All three requesters on the same edge
        vid_req_i = 1'b1; vid_adr_i = 22'h001000;
        snd_req_i = 1'b1; snd_adr_i = 22'h002000;
        cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0;
        cpu_sel_i = 4'hF; cpu_adr_i = 22'h003000;
        push_dma(22'h001000, 0);
        push_dma(22'h002000, 1);
        push_cpu(22'h003000, 1'b0, 4'hF);
        wait_mode = -1; spurious = 1'b1;
        run_traffic(200);
        idle_check(3);

        // CPU write with three wait states
        cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1;
        cpu_sel_i = 4'b0011; cpu_adr_i = 22'h0ABCDE;
        push_cpu(22'h0ABCDE, 1'b1, 4'b0011);
        wait_mode = 3; spurious = 1'b0;
        run_traffic(50);
        idle_check(2);

        // Sound request raised mid video burst; address crosses a carry boundary
        vid_req_i = 1'b1; vid_adr_i = 22'h0001FE;
        push_dma(22'h0001FE, 0);
        late_snd_at = 1; late_snd_adr = 22'h00ABC0;
        wait_mode = 0; spurious = 1'b0;
        run_traffic(100);
        late_snd_at = -1;
        idle_check(2);

        // CPU strobe dropped before grant: no memory cycle
        cpu_cyc_i = 1'b1; cpu_stb_i = 1'b0; cpu_adr_i = 22'h000777;
        idle_check(4);
        cpu_cyc_i = 1'b0;

        // Reset in the middle of a video burst
        vid_req_i = 1'b1; vid_adr_i = 22'h0002A0; mem_ack_i = 1'b0;
        for (int i = 0; i < 10 && !mem_cyc_o; i++) begin @(posedge clkcpu); #1; end
        chk("rstb_started", mem_cyc_o, 1'b1);
        mem_ack_i = 1'b1; #1;
        chk("rstb_ack1", vid_ack_o, 1'b1);
        @(posedge clkcpu); #1;
        chk("rstb_adr2", mem_adr_o, 22'h0002A1);
        chk("rstb_ack2", vid_ack_o, 1'b1);
        @(posedge clkcpu); #1;
        mem_ack_i = 1'b0; rst_n_i = 1'b0;
        chk("rstb_adr3", mem_adr_o, 22'h0002A2);
        @(posedge clkcpu); #1;
        vid_req_i = 1'b0; mem_ack_i = 1'b1; #1;
        chk("rstb_cyc_dropped", mem_cyc_o, 1'b0);
        chk("rstb_no_ack", vid_ack_o, 1'b0);
        @(posedge clkcpu); #1;
        rst_n_i = 1'b1;
        idle_check(3);
        vid_req_i = 1'b1; vid_adr_i = 22'h001234;
        push_dma(22'h001234, 0);
        wait_mode = 0;
        run_traffic(50);
        idle_check(2);

        // Randomized request mixes
        for (int t = 0; t < 25; t++) begin
            v = 1'($urandom); s = 1'($urandom); c = 1'($urandom);
            if (!(v || s || c)) c = 1'b1;
            if (v) begin a = 22'($urandom); vid_req_i = 1'b1; vid_adr_i = a; push_dma(a, 0); end
            if (s) begin a = 22'($urandom); snd_req_i = 1'b1; snd_adr_i = a; push_dma(a, 1); end
            if (c) begin
                a = 22'($urandom);
                cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
                cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom); cpu_adr_i = a;
                push_cpu(a, cpu_we_i, cpu_sel_i);
            end
            wait_mode = -1; spurious = 1'($urandom);
            run_traffic(200);
            idle_check(2);
        end

        // CPU read that memory never acknowledges
        cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0;
        cpu_sel_i = 4'hF; cpu_adr_i = 22'h000155; mem_ack_i = 1'b0;
        for (int i = 0; i < 10 && !mem_cyc_o; i++) begin @(posedge clkcpu); #1; end
        chk("stall_started", mem_cyc_o, 1'b1);
        hi = 0; errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (mem_cyc_o) hi++;
            if (cpu_err_o) begin errs++; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; end
            @(posedge clkcpu); #1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("stall_cyc_cycles", hi, 255);
        chk("stall_err_pulses", errs, 1);
`else
        chk("stall_cyc_cycles", hi, 300);
        chk("stall_err_pulses", errs, 0);
`endif
        rst_n_i = 1'b0;
        @(posedge clkcpu); #1;
        cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; rst_n_i = 1'b1;
        idle_check(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
